// File: rtl/lifo_drain_serializer_if.sv
// Bus between the LIFO drain serializer and its surroundings.
//
// Purpose: bundles the stack-side handshake (pop request, empty flag, data)
// and the serial-side outputs of lifo_drain_serializer.
//
// Signals:
//   Enable      - permits new pops (driven by the environment)
//   LIFO_Empty  - stack empty flag
//   LIFO_Data   - stack registered Data_out
//   Read        - one-cycle pop request to the stack
//   Serial_out  - UART-style serial line, idles high
//   Busy        - high from pop decision through last stop-bit cycle
//   Frame_Done  - one-cycle pulse after a frame completes
//   Words_Sent  - wrapping count of completed frames
//
// Modports: master = the serializer, slave = the stack/sink side.
interface lifo_drain_serializer_if #(
    parameter int unsigned Data_Width  = 8,
    parameter int unsigned Count_Width = 16
);
    logic                   Enable;
    logic                   LIFO_Empty;
    logic [Data_Width-1:0]  LIFO_Data;
    logic                   Read;
    logic                   Serial_out;
    logic                   Busy;
    logic                   Frame_Done;
    logic [Count_Width-1:0] Words_Sent;

    modport master (
        input  Enable,
        input  LIFO_Empty,
        input  LIFO_Data,
        output Read,
        output Serial_out,
        output Busy,
        output Frame_Done,
        output Words_Sent
    );

    modport slave (
        output Enable,
        output LIFO_Empty,
        output LIFO_Data,
        input  Read,
        input  Serial_out,
        input  Busy,
        input  Frame_Done,
        input  Words_Sent
    );
endinterface

// File: rtl/lifo_drain_serializer.sv
// LIFO drain serializer.
//
// Purpose: whenever enabled and the stack is non-empty, pops one word with a
// single-cycle Read pulse, captures the stack's registered Data_out after
// Read_Latency cycles and sends it as start bit (0), data MSB first, stop
// bit (1), each bit held Clocks_Per_Bit cycles.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - lifo_drain_serializer_if master modport (Enable, LIFO_Empty,
//            LIFO_Data in; Read, Serial_out, Busy, Frame_Done, Words_Sent out)
module lifo_drain_serializer #(
    parameter int unsigned Data_Width     = 8,
    parameter int unsigned Read_Latency   = 1,
    parameter int unsigned Clocks_Per_Bit = 4,
    parameter int unsigned Count_Width    = 16
) (
    input logic                     clk,
    input logic                     reset,
    lifo_drain_serializer_if.master bus
);

    localparam int unsigned TimerW = (Clocks_Per_Bit > 1) ? $clog2(Clocks_Per_Bit) : 1;
    localparam int unsigned IdxW   = (Data_Width > 1) ? $clog2(Data_Width) : 1;

    localparam logic [TimerW-1:0] TimerLoad = TimerW'(Clocks_Per_Bit - 1);
    localparam logic [IdxW-1:0]   IdxLoad   = IdxW'(Data_Width - 1);
    localparam logic [1:0]        LatLoad   = 2'(Read_Latency - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic                   read_q, read_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [Count_Width-1:0] sent_q, sent_d;
    logic [Data_Width-1:0]  shift_q, shift_d;
    logic [Data_Width-1:0]  shift_nxt;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [1:0]             lat_q, lat_d;

    assign shift_nxt = shift_q << 1;

    always_comb begin
        state_d  = state_q;
        read_d   = 1'b0;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sent_d   = sent_q;
        shift_d  = shift_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        lat_d    = lat_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Enable && !bus.LIFO_Empty) begin
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StPop;
                end
            end
            StPop: begin
                // Read drops here so the stack sees exactly one pop.
                lat_d   = LatLoad;
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == '0) begin
                    shift_d  = bus.LIFO_Data;
                    serial_d = 1'b0;
                    timer_d  = TimerLoad;
                    state_d  = StStart;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StStart: begin
                if (timer_q == '0) begin
                    serial_d = shift_q[Data_Width-1];
                    idx_d    = IdxLoad;
                    timer_d  = TimerLoad;
                    state_d  = StData;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StData: begin
                if (timer_q == '0) begin
                    timer_d = TimerLoad;
                    if (idx_q == '0) begin
                        serial_d = 1'b1;
                        state_d  = StStop;
                    end else begin
                        shift_d  = shift_nxt;
                        serial_d = shift_nxt[Data_Width-1];
                        idx_d    = idx_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StStop: begin
                if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sent_d  = sent_q + 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            read_q   <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
            shift_q  <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
            shift_q  <= shift_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
        end
    end

    assign bus.Read       = read_q;
    assign bus.Serial_out = serial_q;
    assign bus.Busy       = busy_q;
    assign bus.Frame_Done = done_q;
    assign bus.Words_Sent = sent_q;

endmodule
